// File: rtl/fetch_stage_pkg.sv
// rtl/fetch_stage_pkg.sv - opcode constants, NOP word and fetch state encodings shared by fetch and decode
package fetch_stage_pkg;

    localparam logic [4:0] OP_LDM = 5'b00001;
    localparam logic [4:0] OP_STD = 5'b00010;
    localparam logic [4:0] OP_ADD = 5'b00011;
    localparam logic [4:0] OP_NOP = 5'b00101;
    localparam logic [4:0] OP_SHL = 5'b01111;
    localparam logic [4:0] OP_SHR = 5'b10000;
    localparam logic [4:0] OP_LDD = 5'b10011;

    localparam logic [31:0] NOP_INSTR = {OP_NOP, 27'h0};

    typedef enum logic [1:0] {
        S_BOOT  = 2'b00,
        S_WORD0 = 2'b01,
        S_WORD1 = 2'b10
    } fetch_state_e;

    function automatic logic [4:0] opcode_of(input logic [15:0] word);
        return word[15:11];
    endfunction

endpackage

// File: rtl/fetch_stage_instr_len_decode.sv
// rtl/fetch_stage_instr_len_decode.sv - flags opcodes whose immediate lives in a second memory word
module instr_len_decode
    import fetch_stage_pkg::*;
(
    input  logic [4:0] opcode_i,
    output logic       two_word_o
);

    always_comb begin
        two_word_o = 1'b0;
        case (opcode_i)
            OP_LDM, OP_STD, OP_SHL, OP_SHR, OP_LDD: two_word_o = 1'b1;
            default:                                two_word_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - PC owner and IF/ID word assembler; FETCH_BOOT_VECTOR_EN loads the PC from word 0 after reset
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter int unsigned       ADDR_W       = 16,
    parameter logic [ADDR_W-1:0] RESET_VECTOR = '0
) (
    input  logic              clk,
    input  logic              reset,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [15:0]       imem_data,
    input  logic              stall,
    input  logic              flush,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic [31:0]       instr,
    output logic              instr_valid,
    output logic [ADDR_W-1:0] instr_pc
);

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [15:0]       hi_word_q, hi_word_d;
    logic [ADDR_W-1:0] hi_pc_q, hi_pc_d;
    logic [31:0]       instr_q, instr_d;
    logic              instr_valid_q, instr_valid_d;
    logic [ADDR_W-1:0] instr_pc_q, instr_pc_d;

    logic              two_word;
    logic [ADDR_W-1:0] pc_inc;

    instr_len_decode u_len (
        .opcode_i   (opcode_of(imem_data)),
        .two_word_o (two_word)
    );

    // Wraps modulo 2^ADDR_W, also between the two words of one instruction.
    assign pc_inc = pc_q + {{(ADDR_W-1){1'b0}}, 1'b1};

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        hi_word_d     = hi_word_q;
        hi_pc_d       = hi_pc_q;
        instr_d       = instr_q;
        instr_valid_d = instr_valid_q;
        instr_pc_d    = instr_pc_q;

        if (redirect) begin
            pc_d          = redirect_pc;
            state_d       = S_WORD0;
            instr_d       = NOP_INSTR;
            instr_valid_d = 1'b0;
        end else if (flush) begin
            // Rewind to the first word of the squashed instruction so it is refetched whole.
            instr_d       = NOP_INSTR;
            instr_valid_d = 1'b0;
            state_d       = S_WORD0;
            if (state_q == S_WORD1) begin
                pc_d = hi_pc_q;
            end
        end else if (!stall) begin
            case (state_q)
                S_WORD0: begin
                    pc_d = pc_inc;
                    if (two_word) begin
                        hi_word_d     = imem_data;
                        hi_pc_d       = pc_q;
                        instr_d       = NOP_INSTR;
                        instr_valid_d = 1'b0;
                        state_d       = S_WORD1;
                    end else begin
                        instr_d       = {imem_data, 16'h0000};
                        instr_valid_d = 1'b1;
                        instr_pc_d    = pc_q;
                    end
                end
                S_WORD1: begin
                    instr_d       = {hi_word_q, imem_data};
                    instr_valid_d = 1'b1;
                    instr_pc_d    = hi_pc_q;
                    pc_d          = pc_inc;
                    state_d       = S_WORD0;
                end
`ifdef FETCH_BOOT_VECTOR_EN
                S_BOOT: begin
                    pc_d    = ADDR_W'(imem_data);
                    state_d = S_WORD0;
                end
`endif
                default: begin
                    state_d = S_WORD0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
`ifdef FETCH_BOOT_VECTOR_EN
            state_q <= S_BOOT;
            pc_q    <= '0;
`else
            state_q <= S_WORD0;
            pc_q    <= RESET_VECTOR;
`endif
            hi_word_q     <= '0;
            hi_pc_q       <= '0;
            instr_q       <= NOP_INSTR;
            instr_valid_q <= 1'b0;
            instr_pc_q    <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            hi_word_q     <= hi_word_d;
            hi_pc_q       <= hi_pc_d;
            instr_q       <= instr_d;
            instr_valid_q <= instr_valid_d;
            instr_pc_q    <= instr_pc_d;
        end
    end

    assign imem_addr   = pc_q;
    assign instr       = instr_q;
    assign instr_valid = instr_valid_q;
    assign instr_pc    = instr_pc_q;

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - directed and randomized check of fetch_stage against an instruction-level model
`timescale 1ns/1ps
module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'h2800_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] imem_addr;
    logic [15:0] imem_data;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic        redirect = 1'b0;
    logic [15:0] redirect_pc = 16'h0;
    logic [31:0] instr;
    logic        instr_valid;
    logic [15:0] instr_pc;

    logic [15:0] mem [0:65535];

    int n_vec  = 0;
    int n_miss = 0;

    // Model: address of the instruction being fetched plus words of it already consumed.
    logic [15:0] m_start;
    logic        m_off;
    logic        m_boot;
    logic [31:0] m_instr;
    logic        m_valid;
    logic [15:0] m_ipc;

    always #5 clk = ~clk;

    assign imem_data = mem[imem_addr];

    fetch_stage #(
        .ADDR_W       (16),
        .RESET_VECTOR (16'h0000)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .imem_addr   (imem_addr),
        .imem_data   (imem_data),
        .stall       (stall),
        .flush       (flush),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .instr       (instr),
        .instr_valid (instr_valid),
        .instr_pc    (instr_pc)
    );

    function automatic bit is_two(input logic [15:0] w);
        logic [4:0] op;
        op = w[15:11];
        return op inside {5'd1, 5'd2, 5'd15, 5'd16, 5'd19};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    always @(posedge clk) begin
        logic [15:0] w0;
        logic [15:0] a1;
        if (!reset) begin
            m_start = 16'h0000;
            m_off   = 1'b0;
`ifdef FETCH_BOOT_VECTOR_EN
            m_boot  = 1'b1;
`else
            m_boot  = 1'b0;
`endif
            m_instr = NOP;
            m_valid = 1'b0;
            m_ipc   = 16'h0000;
        end else if (redirect) begin
            m_start = redirect_pc;
            m_off   = 1'b0;
            m_boot  = 1'b0;
            m_instr = NOP;
            m_valid = 1'b0;
        end else if (flush) begin
            m_off   = 1'b0;
            m_boot  = 1'b0;
            m_instr = NOP;
            m_valid = 1'b0;
        end else if (!stall) begin
            if (m_boot) begin
                m_start = mem[m_start];
                m_boot  = 1'b0;
            end else if (!m_off) begin
                w0 = mem[m_start];
                if (is_two(w0)) begin
                    m_off   = 1'b1;
                    m_instr = NOP;
                    m_valid = 1'b0;
                end else begin
                    m_instr = {w0, 16'h0000};
                    m_valid = 1'b1;
                    m_ipc   = m_start;
                    m_start = m_start + 16'd1;
                end
            end else begin
                a1      = m_start + 16'd1;
                m_instr = {mem[m_start], mem[a1]};
                m_valid = 1'b1;
                m_ipc   = m_start;
                m_start = m_start + 16'd2;
                m_off   = 1'b0;
            end
        end
        #1;
        chk("model_instr", instr, m_instr);
        chk("model_valid", {31'h0, instr_valid}, {31'h0, m_valid});
        if (m_valid) chk("model_instr_pc", {16'h0, instr_pc}, {16'h0, m_ipc});
        chk("model_imem_addr", {16'h0, imem_addr}, {16'h0, m_start + {15'h0, m_off}});
    end

    task automatic step(input logic rn, input logic s, input logic f, input logic rd,
                        input logic [15:0] rp);
        @(negedge clk);
        reset       = rn;
        stall       = s;
        flush       = f;
        redirect    = rd;
        redirect_pc = rp;
        @(posedge clk);
        #2;
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 16'($urandom);
`ifdef FETCH_BOOT_VECTOR_EN
        mem[16'h0000] = 16'h0100;
        mem[16'h0100] = 16'h1B20;
        mem[16'h0101] = 16'h2000;
`else
        mem[16'h0000] = 16'h1B20;
        mem[16'h0001] = 16'h2000;
        mem[16'h0002] = 16'h2000;
        mem[16'h0003] = 16'h2000;
        mem[16'h0004] = 16'h0900;
        mem[16'h0005] = 16'hBEEF;
        mem[16'h0006] = 16'h2000;
        mem[16'h0007] = 16'h3000;
        mem[16'h0008] = 16'h2000;
        mem[16'h0010] = 16'h0900;
        mem[16'h0011] = 16'h1234;
        mem[16'h0012] = 16'h2000;
        mem[16'h0040] = 16'h1B20;
        mem[16'h0041] = 16'h2000;
        mem[16'hFFFF] = 16'h7800;
`endif

        @(posedge clk);
        #2;
        chk("rst_instr", instr, NOP);
        chk("rst_valid", {31'h0, instr_valid}, 32'h0);
        chk("rst_instr_pc", {16'h0, instr_pc}, 32'h0);
        chk("rst_imem_addr", {16'h0, imem_addr}, 32'h0);

`ifdef FETCH_BOOT_VECTOR_EN
        step(1, 0, 0, 0, 0);
        chk("boot_addr", {16'h0, imem_addr}, 32'h0100);
        chk("boot_valid", {31'h0, instr_valid}, 32'h0);
        step(1, 0, 0, 0, 0);
        chk("boot_instr", instr, 32'h1B20_0000);
        chk("boot_instr_pc", {16'h0, instr_pc}, 32'h0100);
`else
        step(1, 0, 0, 0, 0);
        chk("c1_instr", instr, 32'h1B20_0000);
        chk("c1_valid", {31'h0, instr_valid}, 32'h1);
        chk("c1_instr_pc", {16'h0, instr_pc}, 32'h0);
        step(1, 0, 0, 0, 0);
        chk("c2_instr_pc", {16'h0, instr_pc}, 32'h1);
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        chk("c4_instr_pc", {16'h0, instr_pc}, 32'h3);
        step(1, 0, 0, 0, 0);
        chk("ldm_bubble", {31'h0, instr_valid}, 32'h0);
        step(1, 0, 0, 0, 0);
        chk("ldm_instr", instr, 32'h0900_BEEF);
        chk("ldm_instr_pc", {16'h0, instr_pc}, 32'h4);
        chk("ldm_pc", {16'h0, imem_addr}, 32'h6);
        step(1, 0, 0, 0, 0);
        for (int k = 0; k < 3; k++) begin
            step(1, 1, 0, 0, 0);
            chk("stall_instr", instr, 32'h2000_0000);
            chk("stall_valid", {31'h0, instr_valid}, 32'h1);
            chk("stall_addr", {16'h0, imem_addr}, 32'h7);
        end
        step(1, 0, 0, 0, 0);
        chk("resume_instr", instr, 32'h3000_0000);
        chk("resume_instr_pc", {16'h0, instr_pc}, 32'h7);
        step(1, 0, 0, 1, 16'h0010);
        step(1, 0, 0, 0, 0);
        chk("flw1_addr", {16'h0, imem_addr}, 32'h11);
        step(1, 0, 1, 0, 0);
        chk("flush_valid", {31'h0, instr_valid}, 32'h0);
        chk("flush_rewind", {16'h0, imem_addr}, 32'h10);
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        chk("refetch_instr", instr, 32'h0900_1234);
        chk("refetch_instr_pc", {16'h0, instr_pc}, 32'h10);
        step(1, 1, 1, 1, 16'h0040);
        chk("redir_addr", {16'h0, imem_addr}, 32'h40);
        chk("redir_valid", {31'h0, instr_valid}, 32'h0);
        step(1, 0, 0, 0, 0);
        chk("redir_instr", instr, 32'h1B20_0000);
        chk("redir_instr_pc", {16'h0, instr_pc}, 32'h40);
        step(1, 0, 0, 1, 16'hFFFF);
        step(1, 0, 0, 0, 0);
        chk("wrap_mid_addr", {16'h0, imem_addr}, 32'h0);
        step(1, 0, 0, 0, 0);
        chk("wrap_instr", instr, 32'h7800_1B20);
        chk("wrap_instr_pc", {16'h0, instr_pc}, 32'hFFFF);
        chk("wrap_pc", {16'h0, imem_addr}, 32'h1);
`endif

        for (int n = 0; n < 4000; n++) begin
            logic        rn;
            logic        s;
            logic        f;
            logic        rd;
            logic [15:0] rp;
            rn = ($urandom_range(0, 149) != 0);
            s  = ($urandom_range(0, 4) == 0);
            f  = ($urandom_range(0, 11) == 0);
            rd = ($urandom_range(0, 15) == 0);
            rp = ($urandom_range(0, 3) == 0) ? (16'hFFF0 | 16'($urandom_range(0, 15)))
                                             : 16'($urandom);
            step(rn, s, f, rd, rp);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage that sits directly upstream of decode and drives its 32-bit instr bus.
- Owns the PC and reads a 16-bit-wide instruction memory. It assembles one-word and two-word (immediate-carrying) instructions into one 32-bit IF/ID word.
- Handles stall, flush and PC redirect from branch/CALL/RET resolution.

Parameters:
- ADDR_W, 16, PC and instruction-memory address width.
- RESET_VECTOR, 16'h0000, PC value loaded on reset (ignored when FETCH_BOOT_VECTOR_EN is defined).

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- imem_addr  out  ADDR_W  instruction-memory address; equals pc (combinational)
- imem_data  in  16  instruction-memory read data; same-cycle combinational read of imem_addr
- stall  in  1  hold the PC, FSM and IF/ID outputs
- flush  in  1  squash the instruction being produced (driven by decode IF_Flush)
- redirect  in  1  load PC from redirect_pc (taken JZ/JN/JC/JMP/CALL, or RET)
- redirect_pc  in  ADDR_W  new PC
- instr  out  32  IF/ID instruction: [31:27] opcode, [26:24] rs, [23:21] rd, [15:0] immediate
- instr_valid  out  1  instr holds a real instruction (0 = bubble)
- instr_pc  out  ADDR_W  address of the first word of instr (return address source for CALL)

Behaviour:
- Reset (reset=0, asynchronous):
  - pc=RESET_VECTOR, state=S_WORD0, instr=NOP_INSTR (32'h2800_0000), instr_valid=0, instr_pc=0, hi_word=0, hi_pc=0.
- Two-word opcodes: LDM 00001, STD 00010, SHL 01111, SHR 10000, LDD 10011. All other opcodes are one-word.
- Word layout: first word fills instr[31:16]. Second word fills instr[15:0]. A one-word instruction has instr[15:0]=0.
- S_WORD0, normal operation:
  - One-word opcode: instr<={imem_data,16'h0}, instr_valid<=1, instr_pc<=pc, pc<=pc+1.
  - Two-word opcode: hi_word<=imem_data, hi_pc<=pc, pc<=pc+1, instr<=NOP_INSTR, instr_valid<=0, go to S_WORD1.
- S_WORD1, normal operation: instr<={hi_word,imem_data}, instr_valid<=1, instr_pc<=hi_pc, pc<=pc+1, go to S_WORD0.
- Latency: one-word instruction reaches instr 1 cycle after its address is presented; two-word instruction 2 cycles, with a bubble in between.
- Priority, highest first: reset > redirect > flush > stall > normal.
- redirect=1: pc<=redirect_pc, state<=S_WORD0, instr<=NOP_INSTR, instr_valid<=0. Applies even with stall=1 or in S_WORD1 (partial fetch discarded).
- flush=1 without redirect: instr<=NOP_INSTR, instr_valid<=0, state<=S_WORD0. The PC rewinds to the squashed instruction's first word:
  - in S_WORD0: pc unchanged;
  - in S_WORD1: pc<=hi_pc.
- stall=1 with no redirect/flush: pc, state, hi_word, instr, instr_valid and instr_pc all hold. imem_addr stays at pc.
- PC arithmetic is modulo 2^ADDR_W: pc=all-ones increments to 0, including between the two words of an instruction.
- Reset asserted mid-instruction (S_WORD1) abandons hi_word with no output.

Optional Feature:
- Macro: FETCH_BOOT_VECTOR_EN.
- Defined:
  - Reset enters S_BOOT with pc=0 and instr_valid=0.
  - The first cycle after reset release: pc<=imem_data[ADDR_W-1:0] (boot vector stored at word 0), go to S_WORD0.
  - redirect during S_BOOT takes priority.
  - RESET_VECTOR unused.
- Undefined: no S_BOOT state; pc=RESET_VECTOR from reset.

Decomposition:
- Shared package/include holds:
  - the 5-bit opcode constants (shared with decode);
  - NOP_INSTR;
  - fetch state encodings S_BOOT/S_WORD0/S_WORD1 (2 bits).
- One sub-module is natural: instr_len_decode, combinational, opcode[4:0] -> two_word. Decode reuses the same opcode list.

Test Plan:
- Reset release, imem[0]=16'h1B20 (ADD), imem[1]=16'h2000 -> cycle 1: instr=32'h1B20_0000, instr_valid=1, instr_pc=0; cycle 2: instr_pc=1.
- LDM at imem[4]=16'h0900, imem[5]=16'hBEEF -> bubble (valid=0) then instr=32'h0900_BEEF, instr_pc=4, pc=6.
- stall=1 for 3 cycles mid-stream -> instr, instr_valid, pc and imem_addr unchanged all 3 cycles; stream resumes with no loss or duplication.
- In S_WORD1 of an LDM at 0x10, pulse flush -> bubble; next cycle imem_addr=0x10 and the LDM is refetched intact.
- redirect=1, redirect_pc=0x0040, together with stall=1 and flush=1 -> next cycle pc=0x0040, instr_valid=0; then the instruction at 0x40 is output.
- pc=16'hFFFF holds a two-word SHL, second word at 0x0000 -> instr assembled correctly, instr_pc=16'hFFFF, pc=1. With FETCH_BOOT_VECTOR_EN and imem[0]=16'h0100, first fetch after reset is from 0x0100.
